// File: rtl/decode_modrm_collect.sv
// Byte-serial collector for ModR/M, optional SIB and 0/1/2/4-byte displacement,
// presented downstream as one registered bundle behind a valid/ready handshake.
module decode_modrm_collect (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_flush,
    input  logic        i_start,
    input  logic        i_addr_size_32,
    input  logic [7:0]  i_byte,
    input  logic        i_byte_valid,
    output logic        o_byte_ready,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [7:0]  o_modrm,
    output logic [7:0]  o_sib,
    output logic        o_sib_present,
    output logic [31:0] o_disp,
    output logic [2:0]  o_disp_size,
    output logic        o_busy
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_MODRM = 3'd1;
    localparam logic [2:0] ST_SIB   = 3'd2;
    localparam logic [2:0] ST_DISP  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Displacement byte count implied by a ModR/M byte that is not followed by SIB.
    function automatic logic [2:0] modrm_disp_size(input logic addr32, input logic [7:0] modrm);
        logic [2:0] n;
        case (modrm[7:6])
            2'b00: begin
                if (addr32) begin
                    n = (modrm[2:0] == 3'b101) ? 3'd4 : 3'd0;
                end else begin
                    n = (modrm[2:0] == 3'b110) ? 3'd2 : 3'd0;
                end
            end
            2'b01:   n = 3'd1;
            2'b10:   n = addr32 ? 3'd4 : 3'd2;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // Displacement byte count once the SIB byte is known (32-bit addressing only).
    function automatic logic [2:0] sib_disp_size(input logic [1:0] mod, input logic [7:0] sib);
        logic [2:0] n;
        case (mod)
            2'b00:   n = (sib[2:0] == 3'b101) ? 3'd4 : 3'd0;
            2'b01:   n = 3'd1;
            2'b10:   n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    logic [2:0]  state_r, state_s;
    logic        addr32_r, addr32_s;
    logic [1:0]  mod_r, mod_s;
    logic [2:0]  disp_n_r, disp_n_s;
    logic [1:0]  cnt_r, cnt_s;
    logic [7:0]  modrm_r, modrm_s;
    logic [7:0]  sib_r, sib_s;
    logic        sib_present_r, sib_present_s;
    logic [31:0] disp_r, disp_s;
    logic [2:0]  disp_size_r, disp_size_s;
    logic        valid_r, busy_r, byte_ready_r;
    logic        take_s, start_s;
    logic [2:0]  n_s;
    logic [31:0] disp_ins_s;

    // Next-state and next-bundle computation; flush wins over everything else.
    always_comb begin
        state_s       = state_r;
        addr32_s      = addr32_r;
        mod_s         = mod_r;
        disp_n_s      = disp_n_r;
        cnt_s         = cnt_r;
        modrm_s       = modrm_r;
        sib_s         = sib_r;
        sib_present_s = sib_present_r;
        disp_s        = disp_r;
        disp_size_s   = disp_size_r;
        n_s           = 3'd0;
        disp_ins_s    = disp_r;
        take_s        = byte_ready_r & i_byte_valid;
        start_s       = i_start & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & i_ready));

        case (cnt_r)
            2'd0:    disp_ins_s[7:0]   = i_byte;
            2'd1:    disp_ins_s[15:8]  = i_byte;
            2'd2:    disp_ins_s[23:16] = i_byte;
            default: disp_ins_s[31:24] = i_byte;
        endcase

        if (i_flush) begin
            state_s = ST_IDLE;
        end else if (start_s) begin
            state_s       = ST_MODRM;
            addr32_s      = i_addr_size_32;
            cnt_s         = 2'd0;
            sib_s         = 8'd0;
            sib_present_s = 1'b0;
            disp_s        = 32'd0;
            disp_size_s   = 3'd0;
        end else begin
            case (state_r)
                ST_MODRM: begin
                    if (take_s) begin
                        modrm_s = i_byte;
                        mod_s   = i_byte[7:6];
                        if (addr32_r && (i_byte[7:6] != 2'b11) && (i_byte[2:0] == 3'b100)) begin
                            state_s = ST_SIB;
                        end else begin
                            n_s         = modrm_disp_size(addr32_r, i_byte);
                            disp_n_s    = n_s;
                            disp_size_s = n_s;
                            state_s     = (n_s != 3'd0) ? ST_DISP : ST_DONE;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_SIB: begin
                    if (take_s) begin
                        sib_s         = i_byte;
                        sib_present_s = 1'b1;
                        n_s           = sib_disp_size(mod_r, i_byte);
                        disp_n_s      = n_s;
                        disp_size_s   = n_s;
                        state_s       = (n_s != 3'd0) ? ST_DISP : ST_DONE;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_DISP: begin
                    if (take_s) begin
                        cnt_s = cnt_r + 2'd1;
                        if (({1'b0, cnt_r} + 3'd1) == disp_n_r) begin
                            // Final byte: sign-extend from the top byte actually fetched.
                            case (disp_n_r)
                                3'd1:    disp_s = {{24{disp_ins_s[7]}}, disp_ins_s[7:0]};
                                3'd2:    disp_s = {{16{disp_ins_s[15]}}, disp_ins_s[15:0]};
                                default: disp_s = disp_ins_s;
                            endcase
                            state_s = ST_DONE;
                        end else begin
                            disp_s = disp_ins_s;
                        end
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_DONE: begin
                    if (i_ready) begin
                        state_s = ST_IDLE;
                    end else begin
                        state_s = state_r;
                    end
                end
                ST_IDLE: state_s = ST_IDLE;
                default: state_s = ST_IDLE;
            endcase
        end
    end

    // State and bundle registers; status flags are decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r       <= ST_IDLE;
            addr32_r      <= 1'b0;
            mod_r         <= 2'd0;
            disp_n_r      <= 3'd0;
            cnt_r         <= 2'd0;
            modrm_r       <= 8'd0;
            sib_r         <= 8'd0;
            sib_present_r <= 1'b0;
            disp_r        <= 32'd0;
            disp_size_r   <= 3'd0;
            valid_r       <= 1'b0;
            busy_r        <= 1'b0;
            byte_ready_r  <= 1'b0;
        end else begin
            state_r       <= state_s;
            addr32_r      <= addr32_s;
            mod_r         <= mod_s;
            disp_n_r      <= disp_n_s;
            cnt_r         <= cnt_s;
            modrm_r       <= modrm_s;
            sib_r         <= sib_s;
            sib_present_r <= sib_present_s;
            disp_r        <= disp_s;
            disp_size_r   <= disp_size_s;
            valid_r       <= (state_s == ST_DONE);
            busy_r        <= (state_s != ST_IDLE);
            byte_ready_r  <= (state_s == ST_MODRM) | (state_s == ST_SIB) | (state_s == ST_DISP);
        end
    end

    // Flush must block consumption in the same cycle, hence the combinational mask.
    assign o_byte_ready  = byte_ready_r & ~i_flush;
    assign o_valid       = valid_r;
    assign o_busy        = busy_r;
    assign o_modrm       = modrm_r;
    assign o_sib         = sib_r;
    assign o_sib_present = sib_present_r;
    assign o_disp        = disp_r;
    assign o_disp_size   = disp_size_r;

endmodule

// File: tb/tb_decode_modrm_collect.sv
// Self-checking bench for decode_modrm_collect: directed vectors plus randomized
// instructions checked against an arithmetic model of the addressing-byte rules.
module tb_decode_modrm_collect;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_flush = 1'b0;
    logic        i_start = 1'b0;
    logic        i_addr_size_32 = 1'b0;
    logic [7:0]  i_byte = 8'd0;
    logic        i_byte_valid = 1'b0;
    logic        i_ready = 1'b0;
    logic        o_byte_ready, o_valid, o_sib_present, o_busy;
    logic [7:0]  o_modrm, o_sib;
    logic [31:0] o_disp;
    logic [2:0]  o_disp_size;

    int total = 0;
    int bad = 0;

    decode_modrm_collect dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_flush(i_flush), .i_start(i_start),
        .i_addr_size_32(i_addr_size_32), .i_byte(i_byte), .i_byte_valid(i_byte_valid),
        .o_byte_ready(o_byte_ready), .o_valid(o_valid), .i_ready(i_ready),
        .o_modrm(o_modrm), .o_sib(o_sib), .o_sib_present(o_sib_present),
        .o_disp(o_disp), .o_disp_size(o_disp_size), .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    // Byte k of the stream sits in bl[8k+7:8k].
    function automatic void model(input logic a32, input logic [47:0] bl,
                                  output logic [7:0] m, output logic [7:0] s,
                                  output logic sp, output int n,
                                  output logic [31:0] d, output int used);
        int md, rm, idx;
        logic [31:0] acc;
        m = bl[7:0];
        md = int'(m[7:6]);
        rm = int'(m[2:0]);
        s = 8'd0; sp = 1'b0; idx = 1;
        if (a32 && md != 3 && rm == 4) begin
            sp = 1'b1; s = bl[15:8]; idx = 2;
        end
        if (md == 1) n = 1;
        else if (md == 2) n = a32 ? 4 : 2;
        else if (md == 0 && a32 && (sp ? (s[2:0] == 3'd5) : (rm == 5))) n = 4;
        else if (md == 0 && !a32 && rm == 6) n = 2;
        else n = 0;
        acc = 32'd0;
        for (int k = 0; k < n; k++) acc = acc + (32'(bl[(idx + k) * 8 +: 8]) << (8 * k));
        if (n > 0 && n < 4 && acc[8 * n - 1]) acc = acc - (32'd1 << (8 * n));
        d = acc;
        used = idx + n;
    endfunction

    task automatic collect(input logic a32, input logic [47:0] bl, input int stall_pct,
                           input logic do_start);
        logic [7:0] em, es; logic esp; int en, eused; logic [31:0] ed;
        int idx, cyc, guard; logic take;
        model(a32, bl, em, es, esp, en, ed, eused);
        cyc = 0;
        if (do_start) begin
            i_start = 1'b1; i_addr_size_32 = a32;
            @(posedge i_clk); #1;
            i_start = 1'b0; cyc = 1;
        end
        idx = 0; guard = 0;
        while (!o_valid && guard < 100) begin
            i_byte = (idx < 6) ? bl[idx * 8 +: 8] : 8'($urandom);
            i_byte_valid = ($urandom_range(0, 99) >= stall_pct);
            #1;
            take = o_byte_ready && i_byte_valid;
            @(posedge i_clk); #1;
            if (take) idx++;
            cyc++; guard++;
        end
        i_byte_valid = 1'b0;
        total++;
        if (!o_valid) begin
            bad++; $display("FAIL collect_timeout: o_valid=%0b want 1", o_valid);
        end
        total++;
        if (idx !== eused) begin
            bad++; $display("FAIL bytes_consumed: got %0d want %0d", idx, eused);
        end
        total++;
        if ({o_modrm, o_sib, o_sib_present, o_disp_size, o_disp} !== {em, es, esp, 3'(en), ed}) begin
            bad++;
            $display("FAIL bundle: got modrm=%h sib=%h sp=%0b n=%0d disp=%h want modrm=%h sib=%h sp=%0b n=%0d disp=%h",
                     o_modrm, o_sib, o_sib_present, o_disp_size, o_disp, em, es, esp, en, ed);
        end
        if (do_start && stall_pct == 0) begin
            total++;
            if (cyc !== 2 + int'(esp) + en) begin
                bad++; $display("FAIL latency: got %0d want %0d", cyc, 2 + int'(esp) + en);
            end
        end
    endtask

    task automatic accept();
        i_ready = 1'b1;
        @(posedge i_clk); #1;
        i_ready = 1'b0;
        total++;
        if ({o_valid, o_busy, o_byte_ready} !== 3'b000) begin
            bad++; $display("FAIL accept: valid/busy/ready=%b want 000", {o_valid, o_busy, o_byte_ready});
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        #12;
        total++;
        if ({o_valid, o_busy, o_byte_ready, o_sib_present} !== 4'b0000) begin
            bad++; $display("FAIL reset_flags: got %b want 0000", {o_valid, o_busy, o_byte_ready, o_sib_present});
        end
        total++;
        if ({o_modrm, o_sib, o_disp, o_disp_size} !== 51'd0) begin
            bad++; $display("FAIL reset_bundle: got %h want 0", {o_modrm, o_sib, o_disp, o_disp_size});
        end
        @(negedge i_clk); i_rst_n = 1'b1;
        @(posedge i_clk); #1;
    endtask

    task automatic test_directed();
        collect(1'b1, 48'h0000_0000_00C3, 0, 1'b1);
        total++;
        if ({o_modrm, o_disp_size, o_disp} !== {8'hC3, 3'd0, 32'd0}) begin
            bad++; $display("FAIL regreg: got %h/%0d/%h want c3/0/0", o_modrm, o_disp_size, o_disp);
        end
        accept();
        collect(1'b1, 48'h0000_00F8_2444, 0, 1'b1);
        total++;
        if (o_disp !== 32'hFFFF_FFF8) begin
            bad++; $display("FAIL sib_disp8: got %h want fffffff8", o_disp);
        end
        accept();
        collect(1'b1, 48'h1234_5678_2504, 0, 1'b1);
        total++;
        if (o_disp !== 32'h1234_5678) begin
            bad++; $display("FAIL sib_disp32: got %h want 12345678", o_disp);
        end
        accept();
        collect(1'b1, 48'h1234_5678_2504, 50, 1'b1);
        total++;
        if (o_disp !== 32'h1234_5678) begin
            bad++; $display("FAIL sib_disp32_stall: got %h want 12345678", o_disp);
        end
        accept();
        collect(1'b0, 48'h0000_0092_3406, 0, 1'b1);
        total++;
        if ({o_disp_size, o_disp} !== {3'd2, 32'hFFFF_9234}) begin
            bad++; $display("FAIL disp16: got %0d/%h want 2/ffff9234", o_disp_size, o_disp);
        end
        accept();
        collect(1'b0, 48'h0000_0080_1184, 0, 1'b1);
        total++;
        if ({o_sib_present, o_disp_size, o_disp} !== {1'b0, 3'd2, 32'hFFFF_8011}) begin
            bad++; $display("FAIL nosib16: got %0b/%0d/%h want 0/2/ffff8011", o_sib_present, o_disp_size, o_disp);
        end
        accept();
    endtask

    task automatic test_handshake();
        collect(1'b1, 48'h0000_00F8_2444, 0, 1'b1);
        i_ready = 1'b0; i_start = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(posedge i_clk); #1;
            total++;
            if ({o_valid, o_byte_ready, o_busy, o_modrm, o_sib, o_disp} !== {3'b101, 8'h44, 8'h24, 32'hFFFF_FFF8}) begin
                bad++; $display("FAIL done_hold: cycle %0d got v=%0b r=%0b modrm=%h sib=%h disp=%h", c,
                                o_valid, o_byte_ready, o_modrm, o_sib, o_disp);
            end
        end
        i_ready = 1'b1; i_addr_size_32 = 1'b0;
        @(posedge i_clk); #1;
        i_ready = 1'b0; i_start = 1'b0;
        total++;
        if ({o_busy, o_valid, o_byte_ready, o_sib_present, o_disp_size, o_disp} !== {4'b1010, 3'd0, 32'd0}) begin
            bad++; $display("FAIL back_to_back: got busy=%0b v=%0b r=%0b sp=%0b n=%0d disp=%h want 1/0/1/0/0/0",
                            o_busy, o_valid, o_byte_ready, o_sib_present, o_disp_size, o_disp);
        end
        collect(1'b0, 48'h0000_0080_1184, 0, 1'b0);
        accept();
    endtask

    task automatic test_random();
        logic a32; logic [47:0] bl;
        for (int t = 0; t < 40; t++) begin
            a32 = 1'($urandom);
            bl = {16'($urandom), 32'($urandom)};
            collect(a32, bl, ($urandom_range(0, 1) == 1) ? 40 : 0, 1'b1);
            accept();
        end
    endtask

    task automatic test_flush();
        i_start = 1'b1; i_addr_size_32 = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_byte_valid = 1'b1;
        i_byte = 8'h80; @(posedge i_clk); #1;
        i_byte = 8'h11; @(posedge i_clk); #1;
        i_byte = 8'h22; @(posedge i_clk); #1;
        i_byte = 8'h33; i_flush = 1'b1;
        #1;
        total++;
        if (o_byte_ready !== 1'b0) begin
            bad++; $display("FAIL flush_ready: got %0b want 0", o_byte_ready);
        end
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        total++;
        if ({o_busy, o_valid} !== 2'b00) begin
            bad++; $display("FAIL flush_idle: busy/valid=%b want 00", {o_busy, o_valid});
        end
        for (int c = 0; c < 6; c++) begin
            @(posedge i_clk); #1;
            total++;
            if ({o_valid, o_byte_ready} !== 2'b00) begin
                bad++; $display("FAIL flush_quiet: cycle %0d valid/ready=%b want 00", c, {o_valid, o_byte_ready});
            end
        end
        i_byte_valid = 1'b0;
        i_start = 1'b1; i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_flush = 1'b0;
        total++;
        if (o_busy !== 1'b0) begin
            bad++; $display("FAIL flush_over_start: busy=%0b want 0", o_busy);
        end
    endtask

    task automatic test_reset_mid();
        i_start = 1'b1; i_addr_size_32 = 1'b1;
        @(posedge i_clk); #1;
        i_start = 1'b0; i_byte = 8'h04; i_byte_valid = 1'b1;
        @(posedge i_clk); #1;
        i_byte_valid = 1'b0;
        total++;
        if ({o_busy, o_byte_ready, o_modrm} !== {2'b11, 8'h04}) begin
            bad++; $display("FAIL in_sib: busy=%0b ready=%0b modrm=%h want 1/1/04", o_busy, o_byte_ready, o_modrm);
        end
        i_rst_n = 1'b0;
        #1;
        total++;
        if ({o_valid, o_busy, o_byte_ready, o_sib_present, o_modrm, o_sib, o_disp, o_disp_size} !== 55'd0) begin
            bad++; $display("FAIL async_reset: got busy=%0b ready=%0b modrm=%h", o_busy, o_byte_ready, o_modrm);
        end
        #2; i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        collect(1'b1, 48'h0000_0000_00C3, 0, 1'b1);
        accept();
    endtask

    initial begin
        test_reset();
        test_directed();
        test_handshake();
        test_random();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_modrm_collect.md
Name: decode_modrm_collect

Overview:
- Byte-serial collector between the prefetch-queue byte stream and the ModR/M / SIB decoders.
- After the opcode decoder signals that an instruction carries a ModR/M byte, this block pulls the following bytes from the stream:
  - the ModR/M byte;
  - an optional SIB byte;
  - a 0/1/2/4-byte little-endian displacement.
- It presents them as one registered bundle with a valid/ready handshake. Downstream SIB and effective-address decode consume the bundle.

Parameters:
- none (widths fixed by the architecture)

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_flush  in  1  synchronous abort (branch / fault); highest priority
- i_start  in  1  begin collection; honoured only in IDLE, or in DONE on the same cycle as the output handshake
- i_addr_size_32  in  1  address size, sampled with i_start; 1 = 32-bit, 0 = 16-bit
- i_byte  in  8  instruction byte from prefetch queue
- i_byte_valid  in  1  i_byte is valid
- o_byte_ready  out  1  block consumes i_byte this cycle if i_byte_valid
- o_valid  out  1  bundle valid
- i_ready  in  1  downstream accepts bundle
- o_modrm  out  8  ModR/M byte
- o_sib  out  8  SIB byte; 0 when absent
- o_sib_present  out  1  SIB byte was fetched
- o_disp  out  32  displacement, sign-extended to 32 bits
- o_disp_size  out  3  displacement byte count: 0, 1, 2 or 4
- o_busy  out  1  state is not IDLE

Behaviour:
- Reset (async, i_rst_n=0):
  - state = IDLE.
  - All outputs 0: o_modrm, o_sib, o_sib_present, o_disp, o_disp_size, o_valid, o_busy, o_byte_ready.
  - Internal byte counter = 0.
- States: IDLE, MODRM, SIB, DISP, DONE.
- o_byte_ready = 1 exactly in MODRM, SIB and DISP; it is a registered-state decode with no combinational path from i_byte_valid. A byte is consumed on a cycle where o_byte_ready & i_byte_valid.
- IDLE:
  - i_start -> MODRM; latch i_addr_size_32; clear o_sib, o_sib_present, o_disp, o_disp_size.
- MODRM, on byte consumed: latch o_modrm; let mod = byte[7:6], rm = byte[2:0].
  - 32-bit address size:
    - mod != 11 and rm = 100 -> SIB.
    - Otherwise displacement size N: mod 00 & rm 101 -> 4; mod 01 -> 1; mod 10 -> 4; else 0.
  - 16-bit address size (never SIB):
    - mod 00 & rm 110 -> 2; mod 01 -> 1; mod 10 -> 2; else 0.
  - N > 0 -> DISP; N = 0 -> DONE.
- SIB, on byte consumed: latch o_sib; set o_sib_present = 1.
  - N: mod 00 & sib[2:0] = 101 -> 4; mod 01 -> 1; mod 10 -> 4; else 0.
  - N > 0 -> DISP; else DONE.
- DISP:
  - o_disp_size = N from entry.
  - The k-th consumed byte (k = 0..N-1) writes disp[8k+7:8k], little-endian.
  - On the last byte, sign-extend from bit 8N-1 to 32 bits, then go to DONE.
  - Stalls (i_byte_valid = 0) hold all state.
- DONE:
  - o_valid = 1; outputs stable until the handshake.
  - o_valid & i_ready -> IDLE, or -> MODRM if i_start is asserted in that cycle (back-to-back; new address size sampled, bundle fields cleared).
  - i_start in DONE without i_ready is ignored.
- Latency:
  - o_valid rises in the cycle after the final byte is consumed.
  - Minimum IDLE-to-o_valid is 2 + sib + N cycles with no stalls.
- i_flush:
  - Next state IDLE from any state.
  - o_valid and o_busy drop next cycle; a byte presented in that cycle is not consumed (o_byte_ready is forced 0 combinationally when i_flush = 1).
  - Overrides i_start in the same cycle.
- o_busy = (state != IDLE).
- i_start while in MODRM, SIB or DISP is ignored.
- Reset asserted mid-collection returns to IDLE immediately, with all outputs at reset values.

Test Plan:
- Reg-reg, 32-bit: start, byte C3 (mod11) -> o_valid next cycle; o_modrm = C3, o_sib_present = 0, o_disp_size = 0, o_disp = 0.
- 32-bit SIB + disp8: bytes 44, 24, F8 -> o_sib = 24, o_sib_present = 1, o_disp_size = 1, o_disp = FFFF_FFF8.
- 32-bit SIB base101 mod00: bytes 04, 25, 78, 56, 34, 12 -> o_disp_size = 4, o_disp = 1234_5678; i_byte_valid toggled low between bytes -> same result, no byte lost or duplicated.
- 16-bit direct: i_addr_size_32 = 0, bytes 06, 34, 92 -> o_disp_size = 2, o_disp = FFFF_9234; a following 84 in 16-bit mode -> no SIB (mod 10 -> disp16).
- Handshake: hold i_ready = 0 for 5 cycles in DONE -> outputs stable, o_byte_ready = 0; i_ready = 1 with i_start -> MODRM next cycle, o_busy stays 1.
- Flush/reset: i_flush during DISP after 2 of 4 bytes -> IDLE next cycle, o_valid never asserted; async i_rst_n low mid-SIB -> all outputs 0 immediately.
